// File: rtl/axis_width_downsizer.sv
// rtl/axis_width_downsizer.sv - AXI-Stream width downsizer, splits wide beats into narrow lanes LSB first.
// Lanes with all-zero TKEEP are skipped; TLAST moves to the last emitted lane.
module axis_width_downsizer #(
    parameter int S_DATA_WIDTH = 32,
    parameter int M_DATA_WIDTH = 8,
    parameter int USER_WIDTH   = 8,
    parameter int ID_WIDTH     = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    input  logic [S_DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [S_DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic [USER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic [ID_WIDTH-1:0]       S_AXIS_TID,
    input  logic                      S_AXIS_TLAST,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic [M_DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [M_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic [USER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic [ID_WIDTH-1:0]       M_AXIS_TID,
    output logic                      M_AXIS_TLAST
);

    localparam int RATIO     = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int LANE_KEEP = M_DATA_WIDTH / 8;
    localparam int S_KEEP    = S_DATA_WIDTH / 8;
    localparam int IDX_W     = $clog2(RATIO);

    typedef enum logic {EMPTY, SEND} state_t;

    state_t                  state_q, state_d;
    logic [S_DATA_WIDTH-1:0] data_q, data_d;
    logic [S_KEEP-1:0]       keep_q, keep_d;
    logic [USER_WIDTH-1:0]   user_q, user_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    last_q, last_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [RATIO-1:0] live_held;
    logic [RATIO-1:0] live_in;
    logic [IDX_W-1:0] first_in;
    logic [IDX_W-1:0] next_idx;
    logic             has_next;
    logic             any_in;
    logic             full;
    logic             lane_final;
    logic             load;

    always_comb begin
        live_held = '0;
        live_in   = '0;
        for (int i = 0; i < RATIO; i++) begin
            live_held[i] = |keep_q[i*LANE_KEEP +: LANE_KEEP];
            live_in[i]   = |S_AXIS_TKEEP[i*LANE_KEEP +: LANE_KEEP];
        end
    end

    // Descending scans leave the lowest qualifying lane as the winner.
    always_comb begin
        first_in = '0;
        next_idx = idx_q;
        has_next = 1'b0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (live_in[i]) begin
                first_in = IDX_W'(i);
            end
            if (live_held[i] && (i > int'(idx_q))) begin
                has_next = 1'b1;
                next_idx = IDX_W'(i);
            end
        end
    end

    assign any_in        = |live_in;
    assign full          = (state_q == SEND);
    assign lane_final    = ~has_next;
    assign S_AXIS_TREADY = ~RST & (~full | (M_AXIS_TREADY & lane_final));
    assign load          = S_AXIS_TVALID & S_AXIS_TREADY;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        keep_d  = keep_q;
        user_d  = user_q;
        id_d    = id_q;
        last_d  = last_q;
        idx_d   = idx_q;
        if (full && M_AXIS_TREADY) begin
            if (has_next) begin
                idx_d = next_idx;
            end else begin
                state_d = EMPTY;
            end
        end
        // A beat with no live lanes and no TLAST is absorbed without ever going full.
        if (load) begin
            data_d  = S_AXIS_TDATA;
            keep_d  = S_AXIS_TKEEP;
            user_d  = S_AXIS_TUSER;
            id_d    = S_AXIS_TID;
            last_d  = S_AXIS_TLAST;
            idx_d   = first_in;
            state_d = (any_in || S_AXIS_TLAST) ? SEND : EMPTY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= EMPTY;
            data_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            id_q    <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            user_q  <= user_d;
            id_q    <= id_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign M_AXIS_TVALID = full;
    assign M_AXIS_TDATA  = full ? data_q[int'(idx_q)*M_DATA_WIDTH +: M_DATA_WIDTH] : '0;
    assign M_AXIS_TKEEP  = full ? keep_q[int'(idx_q)*LANE_KEEP +: LANE_KEEP] : '0;
    assign M_AXIS_TUSER  = full ? user_q : '0;
    assign M_AXIS_TID    = full ? id_q : '0;
    assign M_AXIS_TLAST  = full & last_q & lane_final;

endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb/tb_axis_width_downsizer.sv - randomized bench for axis_width_downsizer against a lane-queue model.
module tb_axis_width_downsizer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TKEEP;
    logic [7:0]  S_AXIS_TUSER;
    logic [3:0]  S_AXIS_TID;
    logic        S_AXIS_TLAST;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [7:0]  M_AXIS_TDATA;
    logic [0:0]  M_AXIS_TKEEP;
    logic [7:0]  M_AXIS_TUSER;
    logic [3:0]  M_AXIS_TID;
    logic        M_AXIS_TLAST;

    axis_width_downsizer #(
        .S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .USER_WIDTH(8), .ID_WIDTH(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP),
        .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TID(S_AXIS_TID), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TID(M_AXIS_TID), .M_AXIS_TLAST(M_AXIS_TLAST)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] data;
        logic       keep;
        logic [7:0] user;
        logic [3:0] id;
        logic       last;
    } lane_t;

    lane_t exp_q[$];
    int    n_chk     = 0;
    int    n_pass    = 0;
    int    lanes_out = 0;
    bit    rand_bp   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected narrow stream of one accepted wide beat, built byte by byte.
    task automatic push_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [7:0] u, input logic [3:0] id);
        int    hi;
        lane_t e;
        hi = -1;
        for (int i = 0; i < 4; i++) if (k[i]) hi = i;
        if (hi < 0) begin
            if (l) begin
                e.data = d[7:0]; e.keep = 1'b0; e.user = u; e.id = id; e.last = 1'b1;
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (k[i]) begin
                    e.data = d[i*8 +: 8]; e.keep = 1'b1; e.user = u; e.id = id;
                    e.last = l && (i == hi);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    always @(negedge CLK) begin
        lane_t e;
        if (RST) begin
            chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'(0));
            exp_q.delete();
        end else begin
            chk("m_tvalid", 64'(M_AXIS_TVALID), 64'(exp_q.size() != 0));
            chk("s_tready", 64'(S_AXIS_TREADY),
                64'((exp_q.size() == 0) || (exp_q.size() == 1 && M_AXIS_TREADY)));
            if (M_AXIS_TVALID && exp_q.size() != 0) begin
                e = exp_q[0];
                chk("m_tdata", 64'(M_AXIS_TDATA), 64'(e.data));
                chk("m_tkeep", 64'(M_AXIS_TKEEP), 64'(e.keep));
                chk("m_tlast", 64'(M_AXIS_TLAST), 64'(e.last));
                chk("m_tuser", 64'(M_AXIS_TUSER), 64'(e.user));
                chk("m_tid",   64'(M_AXIS_TID),   64'(e.id));
                if (M_AXIS_TREADY) begin
                    void'(exp_q.pop_front());
                    lanes_out++;
                end
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY)
                push_beat(S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TID);
        end
    end

    initial begin
        M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            M_AXIS_TREADY = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                             input logic [7:0] u, input logic [3:0] id);
        bit done;
        bit acc;
        done = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TKEEP  = k;
        S_AXIS_TLAST  = l;
        S_AXIS_TUSER  = u;
        S_AXIS_TID    = id;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge CLK);
            acc = S_AXIS_TREADY;
            @(posedge CLK);
            #1;
            if (acc) done = 1'b1;
        end
        if (!done) chk("s_accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        S_AXIS_TVALID = 1'b0;
        for (int c = 0; c < 1000 && exp_q.size() != 0; c++) begin
            @(posedge CLK);
            #1;
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int mark;
        RST = 1'b1;
        S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0;
        S_AXIS_TUSER = '0; S_AXIS_TID = '0; S_AXIS_TLAST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        chk("reset_tdata",  64'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TID, M_AXIS_TLAST}), 64'(0));
        chk("reset_tready", 64'(S_AXIS_TREADY), 64'(1));
        @(posedge CLK);
        #1;

        send_beat(32'h44332211, 4'hF, 1'b1, 8'hA5, 4'd3);
        drain();
        send_beat(32'hDDCCBBAA, 4'hA, 1'b1, 8'h11, 4'd1);
        drain();
        send_beat(32'h12345678, 4'h0, 1'b0, 8'h22, 4'd2);
        drain();
        send_beat(32'h87654321, 4'h0, 1'b1, 8'h33, 4'd4);
        drain();

        for (int b = 0; b < 8; b++)
            send_beat($urandom, 4'hF, b == 7, 8'h5A, 4'd6);
        drain();

        rand_bp = 1'b1;
        for (int b = 0; b < 100; b++)
            send_beat($urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                      8'($urandom), 4'($urandom));
        drain();
        rand_bp = 1'b0;
        @(posedge CLK);
        #1;

        mark = lanes_out;
        send_beat(32'h04030201, 4'hF, 1'b1, 8'h77, 4'd7);
        S_AXIS_TVALID = 1'b0;
        for (int c = 0; c < 20 && lanes_out < mark + 2; c++) begin
            @(posedge CLK);
            #1;
        end
        chk("mid_two_lanes", 64'(lanes_out - mark), 64'(2));
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        @(posedge CLK);
        #1;
        send_beat(32'hC3C2C1C0, 4'hF, 1'b0, 8'h99, 4'd9);
        send_beat(32'hD3D2D1D0, 4'h7, 1'b1, 8'h99, 4'd9);
        drain();
        repeat (3) @(posedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axis_width_downsizer.md
# axis_width_downsizer

AXI-Stream width downconverter that splits each wide input beat into RATIO = S_DATA_WIDTH/M_DATA_WIDTH narrow output lanes, least-significant lane first. It sits directly downstream of the AXI-Stream synchronous FIFO, consuming its M_AXIS side and feeding narrow consumers such as byte-wide MACs and serializers. Lanes whose TKEEP slice is all zero are skipped, and TLAST is moved to the last emitted lane. One input register gives a one-cycle latency, and the block accepts back-to-back input beats without bubbles.

## Interface
- S_DATA_WIDTH, 32: input TDATA width. Must be a multiple of M_DATA_WIDTH.
- M_DATA_WIDTH, 8: output TDATA width. Must be a multiple of 8.
- USER_WIDTH, 8: TUSER width. Passed through unchanged on every lane of a beat.
- ID_WIDTH, 4: TID width. Passed through unchanged on every lane of a beat.
- Derived: RATIO = S_DATA_WIDTH/M_DATA_WIDTH, which must be a power of two ≥ 2. LANE_KEEP = M_DATA_WIDTH/8.
- Ports:
  - CLK  in  1  single clock; all logic on rising edge.
  - RST  in  1  synchronous, active-high reset.
  - S_AXIS_TVALID  in  1  input beat valid.
  - S_AXIS_TREADY  out  1  block can accept an input beat.
  - S_AXIS_TDATA  in  S_DATA_WIDTH  wide data.
  - S_AXIS_TKEEP  in  S_DATA_WIDTH/8  byte qualifiers.
  - S_AXIS_TUSER  in  USER_WIDTH  sideband.
  - S_AXIS_TID  in  ID_WIDTH  stream ID.
  - S_AXIS_TLAST  in  1  end of packet.
  - M_AXIS_TVALID  out  1  output lane valid.
  - M_AXIS_TREADY  in  1  downstream accepts the lane.
  - M_AXIS_TDATA  out  M_DATA_WIDTH  lane data.
  - M_AXIS_TKEEP  out  LANE_KEEP  lane byte qualifiers.
  - M_AXIS_TUSER  out  USER_WIDTH  copy of the held beat's TUSER.
  - M_AXIS_TID  out  ID_WIDTH  copy of the held beat's TID.
  - M_AXIS_TLAST  out  1  asserted on the last emitted lane of a TLAST beat.

## Operation
- Holding register stores TDATA, TKEEP, TUSER, TID and TLAST of one input beat, plus a `full` flag and a lane index `idx` (log2(RATIO) bits).
- Lane i is TDATA[i*M+:M], with TKEEP slice [i*LANE_KEEP+:LANE_KEEP]. A lane is "live" if its TKEEP slice is nonzero.
- States:
  - EMPTY (full=0).
  - SEND (full=1, idx = current live lane).
- On load:
  - idx = lowest live lane.
  - If no lane is live and TLAST=1: emit lane 0 once with TKEEP=0 and TLAST=1.
  - If no lane is live and TLAST=0: drop the beat. full stays 0, no output, and S_AXIS_TREADY stays 1.
- On an M handshake in SEND:
  - If a higher live lane exists, idx advances to the lowest such lane. Lane indices increase monotonically, never wrapping inside a beat.
  - Otherwise the lane is final: the beat is retired.
- Final lane = the highest live lane, or lane 0 in the null-TLAST case. M_AXIS_TLAST = held TLAST AND (current lane is final). Always 0 otherwise.
- S_AXIS_TREADY = ~full OR (M_AXIS_TREADY AND current lane is final). This is combinational from M_AXIS_TREADY.
- Simultaneous retire and load: the new beat overwrites the register in the same cycle, full stays 1, and idx = the new beat's first live lane.
- TDATA, TKEEP, TUSER and TID are not altered, except that lane TKEEP is an exact slice.

## Timing
- Reset: full=0, idx=0, M_AXIS_TVALID=0, and M_AXIS_TDATA, TKEEP, TUSER, TID and TLAST all 0.
- S_AXIS_TREADY is 0 while RST=1 and 1 in the first cycle after RST deasserts.
- Latency: an input accepted at edge n gives M_AXIS_TVALID=1 from edge n (visible in cycle n+1).
- Throughput: one output lane per cycle while M_AXIS_TREADY=1. A beat with k live lanes occupies k cycles. No bubble between beats.
- Backpressure: while M_AXIS_TVALID=1 and M_AXIS_TREADY=0, all M outputs hold stable.
- Reset mid-packet: the held beat is discarded, no TLAST is emitted, and the state returns to EMPTY on the next edge.

## Test plan
- Reset then a single beat:
  - Stimulus: 0x44332211, TKEEP=0xF, TLAST=1, TUSER=0xA5, TID=3, with M_DATA_WIDTH=8 and M_AXIS_TREADY held 1.
  - Required response: outputs 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles. TLAST only on 0x44. TUSER=0xA5 and TID=3 on all 4. S_AXIS_TREADY=0 for cycles 1-3.
- Sparse keep:
  - Stimulus: TDATA=0xDDCCBBAA, TKEEP=0xA (0b1010), TLAST=1.
  - Required response: exactly 2 outputs, 0xBB then 0xDD, with TLAST on 0xDD.
- Null beats:
  - Stimulus: TKEEP=0, TLAST=0.
  - Required response: no output, and TREADY stays 1.
  - Stimulus: TKEEP=0, TLAST=1.
  - Required response: one output, TKEEP=0, TLAST=1.
- Back-to-back streaming:
  - Stimulus: 8 full beats, TVALID held 1, TLAST on beat 8.
  - Required response: 32 contiguous outputs with no idle cycle. TLAST on output 32 only.
- Random backpressure:
  - Stimulus: M_AXIS_TREADY toggling pseudo-randomly over 100 beats with random keep.
  - Required response: output byte stream equals the input bytes with TKEEP=1, in order. Outputs stay stable while stalled.
- Reset mid-beat:
  - Stimulus: assert RST after the 2nd lane of a 4-lane beat.
  - Required response: the next cycle shows M_AXIS_TVALID=0. The following packet is emitted intact with no residue.
